// File: rtl/sd_block_writer.sv
// SPI-mode SD single-block write controller: CMD24, 512-byte data block from a
// synchronous buffer RAM, data-response check, busy wait, then done/error report.
module sd_block_writer #(
    parameter int R1_POLL_MAX   = 8,
    parameter int BUSY_POLL_MAX = 65535,
    parameter int NCR_TAIL      = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        wr_req,
    input  logic [31:0] addr,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  err_code,
    output logic [8:0]  buf_rd_addr,
    input  logic [7:0]  buf_rd_data,
    output logic        spi_cs,
    output logic [7:0]  spi_tx_data,
    output logic        spi_start,
    input  logic        spi_done,
    input  logic [7:0]  spi_rx_data
);

    localparam logic [15:0] R1_MAX   = 16'(R1_POLL_MAX);
    localparam logic [15:0] BUSY_MAX = 16'(BUSY_POLL_MAX);
    localparam logic [15:0] TAIL_N   = 16'(NCR_TAIL);

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_R1WAIT, S_GAP, S_TOKEN, S_DATA, S_CRC,
        S_DRESP, S_BUSY, S_TAIL, S_ERRFF, S_FINISH
    } state_t;

    // Each send state cycles LAUNCH -> WAIT; DATA inserts FETCH for the RAM read latency.
    typedef enum logic [1:0] {PH_LAUNCH, PH_WAIT, PH_FETCH} phase_t;

    state_t      state_r, state_s;
    phase_t      phase_r, phase_s;
    logic [31:0] addr_r, addr_s;
    logic [15:0] cnt_r, cnt_s, cnt_inc_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        err_r, err_s;
    logic [2:0]  err_code_r, err_code_s;
    logic [8:0]  buf_addr_r, buf_addr_s;
    logic        cs_r, cs_s;
    logic [7:0]  tx_r, tx_s, tx_byte_s;
    logic        start_r, start_s;
    logic        fail_s;
    logic [2:0]  fail_code_s;

    // Byte to transmit for the current state and byte index.
    always_comb begin
        tx_byte_s = 8'hFF;
        case (state_r)
            S_CMD: begin
                case (cnt_r[2:0])
                    3'd0:    tx_byte_s = 8'h58;
                    3'd1:    tx_byte_s = addr_r[31:24];
                    3'd2:    tx_byte_s = addr_r[23:16];
                    3'd3:    tx_byte_s = addr_r[15:8];
                    3'd4:    tx_byte_s = addr_r[7:0];
                    default: tx_byte_s = 8'hFF;
                endcase
            end
            S_TOKEN: tx_byte_s = 8'hFE;
            S_DATA:  tx_byte_s = buf_rd_data;
            default: tx_byte_s = 8'hFF;
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s     = state_r;
        phase_s     = phase_r;
        addr_s      = addr_r;
        cnt_s       = cnt_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
        err_s       = err_r;
        err_code_s  = err_code_r;
        buf_addr_s  = buf_addr_r;
        cs_s        = cs_r;
        tx_s        = tx_r;
        start_s     = 1'b0;
        fail_s      = 1'b0;
        fail_code_s = 3'd0;
        cnt_inc_s   = (cnt_r == 16'hFFFF) ? cnt_r : cnt_r + 16'd1;

        case (state_r)
            S_IDLE: begin
                // A request coinciding with the done pulse is not taken.
                if (wr_req && !done_r) begin
                    addr_s     = addr;
                    busy_s     = 1'b1;
                    err_s      = 1'b0;
                    err_code_s = 3'd0;
                    cs_s       = 1'b0;
                    cnt_s      = 16'd0;
                    buf_addr_s = 9'd0;
                    phase_s    = PH_LAUNCH;
                    state_s    = S_CMD;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_FINISH: begin
                done_s  = 1'b1;
                busy_s  = 1'b0;
                state_s = S_IDLE;
            end
            S_CMD, S_R1WAIT, S_GAP, S_TOKEN, S_DATA, S_CRC,
            S_DRESP, S_BUSY, S_TAIL, S_ERRFF: begin
                case (phase_r)
                    PH_FETCH: phase_s = PH_LAUNCH;
                    PH_LAUNCH: begin
                        start_s = 1'b1;
                        tx_s    = tx_byte_s;
                        phase_s = PH_WAIT;
                    end
                    PH_WAIT: begin
                        if (spi_done) begin
                            phase_s = PH_LAUNCH;
                            case (state_r)
                                S_CMD: begin
                                    if (cnt_r == 16'd5) begin
                                        cnt_s   = 16'd0;
                                        state_s = S_R1WAIT;
                                    end else begin
                                        cnt_s = cnt_inc_s;
                                    end
                                end
                                S_R1WAIT: begin
                                    if (!spi_rx_data[7]) begin
                                        if (spi_rx_data == 8'h00) begin
                                            cnt_s   = 16'd0;
                                            state_s = S_GAP;
                                        end else begin
                                            fail_s      = 1'b1;
                                            fail_code_s = 3'd2;
                                        end
                                    end else if (cnt_inc_s >= R1_MAX) begin
                                        fail_s      = 1'b1;
                                        fail_code_s = 3'd1;
                                    end else begin
                                        cnt_s = cnt_inc_s;
                                    end
                                end
                                S_GAP:   state_s = S_TOKEN;
                                S_TOKEN: begin
                                    buf_addr_s = 9'd0;
                                    phase_s    = PH_FETCH;
                                    state_s    = S_DATA;
                                end
                                S_DATA: begin
                                    if (buf_addr_r == 9'd511) begin
                                        cnt_s   = 16'd0;
                                        state_s = S_CRC;
                                    end else begin
                                        buf_addr_s = buf_addr_r + 9'd1;
                                        phase_s    = PH_FETCH;
                                    end
                                end
                                S_CRC: begin
                                    if (cnt_r == 16'd1) begin
                                        cnt_s   = 16'd0;
                                        state_s = S_DRESP;
                                    end else begin
                                        cnt_s = cnt_inc_s;
                                    end
                                end
                                S_DRESP: begin
                                    if (spi_rx_data[4:0] == 5'h05) begin
                                        cnt_s   = 16'd0;
                                        state_s = S_BUSY;
                                    end else begin
                                        fail_s      = 1'b1;
                                        fail_code_s = 3'd3;
                                    end
                                end
                                S_BUSY: begin
                                    // Any nonzero byte ends busy, even on the last allowed poll.
                                    if (spi_rx_data != 8'h00) begin
                                        cnt_s = 16'd0;
                                        if (TAIL_N == 16'd0) begin
                                            cs_s    = 1'b1;
                                            state_s = S_FINISH;
                                        end else begin
                                            state_s = S_TAIL;
                                        end
                                    end else if (cnt_inc_s >= BUSY_MAX) begin
                                        fail_s      = 1'b1;
                                        fail_code_s = 3'd4;
                                    end else begin
                                        cnt_s = cnt_inc_s;
                                    end
                                end
                                S_TAIL: begin
                                    if (cnt_inc_s >= TAIL_N) begin
                                        cs_s    = 1'b1;
                                        state_s = S_FINISH;
                                    end else begin
                                        cnt_s = cnt_inc_s;
                                    end
                                end
                                S_ERRFF: begin
                                    cs_s    = 1'b1;
                                    state_s = S_FINISH;
                                end
                                default: state_s = S_IDLE;
                            endcase
                        end else begin
                            phase_s = PH_WAIT;
                        end
                    end
                    default: phase_s = PH_LAUNCH;
                endcase
            end
            default: begin
                cs_s    = 1'b1;
                busy_s  = 1'b0;
                state_s = S_IDLE;
            end
        endcase

        // Errors send one trailing 0xFF with CS still low before finishing.
        if (fail_s) begin
            err_s      = 1'b1;
            err_code_s = fail_code_s;
            cnt_s      = 16'd0;
            phase_s    = PH_LAUNCH;
            state_s    = S_ERRFF;
        end else begin
            err_s = err_s;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= S_IDLE;
            phase_r    <= PH_LAUNCH;
            addr_r     <= 32'd0;
            cnt_r      <= 16'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            err_code_r <= 3'd0;
            buf_addr_r <= 9'd0;
            cs_r       <= 1'b1;
            tx_r       <= 8'hFF;
            start_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            phase_r    <= phase_s;
            addr_r     <= addr_s;
            cnt_r      <= cnt_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            err_r      <= err_s;
            err_code_r <= err_code_s;
            buf_addr_r <= buf_addr_s;
            cs_r       <= cs_s;
            tx_r       <= tx_s;
            start_r    <= start_s;
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign err         = err_r;
    assign err_code    = err_code_r;
    assign buf_rd_addr = buf_addr_r;
    assign spi_cs      = cs_r;
    assign spi_tx_data = tx_r;
    assign spi_start   = start_r;

endmodule

// File: doc/sd_block_writer.md
Name: sd_block_writer

Overview:
- SD-card single-block write controller in SPI mode, for use after card initialisation is complete.
- On request it issues CMD24, streams one 512-byte block from a local buffer RAM, checks the data-response token, waits out card busy, then reports done or error.
- It drives a byte-level full-duplex SPI engine through a start/done handshake. It is the write-direction counterpart of the block-read path.

Parameters:
- R1_POLL_MAX, 8: maximum 0xFF fill bytes clocked while waiting for the R1 response.
- BUSY_POLL_MAX, 65535: maximum bytes clocked while the card holds MISO low (busy).
- NCR_TAIL, 1: 0xFF bytes sent after busy ends, before CS is released.

Ports:
- CLK  in  1  single clock (SPI engine clock domain)
- RST  in  1  synchronous, active-high reset
- wr_req  in  1  level or pulse; sampled only in IDLE
- addr  in  32  card block/byte address; latched when the request is accepted
- busy  out  1  high from acceptance until done
- done  out  1  one-cycle pulse at end of every transaction, success or error
- err  out  1  valid with done; held until the next acceptance
- err_code  out  3  0 none, 1 R1 timeout, 2 R1 nonzero, 3 data rejected, 4 busy timeout
- buf_rd_addr  out  9  buffer RAM read address
- buf_rd_data  in  8  buffer RAM data, valid 1 cycle after address (synchronous RAM)
- spi_cs  out  1  card chip select, active low
- spi_tx_data  out  8  byte to send; stable from spi_start until spi_done
- spi_start  out  1  one-cycle pulse that launches one byte transfer
- spi_done  in  1  one-cycle pulse; transfer finished, spi_rx_data valid
- spi_rx_data  in  8  byte received during the finished transfer

Behaviour:
- Reset values:
  - busy=0, done=0, err=0, err_code=0
  - spi_cs=1, spi_start=0, spi_tx_data=0xFF, buf_rd_addr=0
  - state IDLE, all counters 0
- Reset mid-transaction: return to IDLE in the same edge, drop CS to 1, no done pulse.
- Byte rule: exactly one outstanding transfer. spi_start is issued only in the cycle after entering a send state, or after the previous spi_done. spi_done outside a wait state is ignored.
- IDLE:
  - On wr_req: latch addr, busy=1, err=0, err_code=0, spi_cs=0, go to CMD.
- CMD:
  - Send 6 bytes: 0x58, addr[31:24], addr[23:16], addr[15:8], addr[7:0], 0xFF (CRC is don't-care in SPI mode).
  - Then go to R1WAIT.
- R1WAIT:
  - Send 0xFF repeatedly.
  - First rx byte with bit7=0 is R1. R1==0x00 -> GAP; otherwise error 2.
  - If R1_POLL_MAX bytes arrive with bit7=1 -> error 1.
- GAP: send one 0xFF.
- TOKEN: send 0xFE.
- DATA: for i=0..511:
  - Present buf_rd_addr=i, wait 1 cycle.
  - Issue spi_start with spi_tx_data=buf_rd_data.
  - Wait for spi_done.
  - The 9-bit index increments; after i=511, go to CRC (no wrap is used).
- CRC: send 0xFF, 0xFF.
- DRESP:
  - Send 0xFF, inspect rx.
  - (rx & 0x1F)==0x05 -> BUSY.
  - Any other value -> error 3.
- BUSY:
  - Send 0xFF repeatedly while rx==0x00.
  - First nonzero rx -> TAIL.
  - If the count reaches BUSY_POLL_MAX (16-bit counter, saturating compare) -> error 4.
- TAIL: send NCR_TAIL x 0xFF, then spi_cs=1, go to FINISH.
- FINISH: done=1 for one cycle, busy=0, back to IDLE.
- Error path:
  - Latch err=1 and err_code.
  - Finish the current byte, send one 0xFF with CS low, raise CS, then FINISH.
- Simultaneous wr_req and done: the request is ignored unless wr_req is still high in IDLE next cycle.
- wr_req while busy is ignored.
- addr changes after acceptance have no effect.
- Latency: at least 1 + 6 + R1 bytes + 1 + 1 + 512×(fetch+xfer) + 2 + 1 + busy + tail transfers.

Test Plan:
- Normal write:
  - Stimulus: buffer[i]=i[7:0]; addr=0x0000_0200; card model R1=0x00 on the 2nd poll, token resp 0xE5, busy 10 bytes of 0x00.
  - Required: MOSI bytes 58 00 00 02 00 FF, FF, FE, 00..FF twice, FF FF; then done with err=0; spi_cs low throughout, high before done.
- R1 timeout: card returns 0xFF forever -> exactly 8 polls, done, err_code=1, CS high.
- R1 reject: R1=0x05 -> err_code=2, no 0xFE token sent.
- Data reject: response 0x0B -> err_code=3, no busy polling.
- Busy timeout: BUSY_POLL_MAX=16, card holds 0x00 -> exactly 16 busy bytes, then err_code=4.
- Robustness:
  - wr_req pulsed during DATA -> ignored.
  - RST asserted at byte 100 -> next cycle spi_cs=1, busy=0, no done.
  - A new request after that completes normally with buf_rd_addr restarting at 0.
